time_set_controller: RTL

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/clock_pkg.sv | 15 +
 rtl/bcd2_counter.sv | 42 ++++
 rtl/time_set_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS time-setting clock: mode encoding,
// BCD digit width and field limits.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    localparam int BCD_W      = 4;
    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter 00..MAX. The carry is combinational so that the next
// field can advance on the same edge as this one wraps.
module bcd2_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units,
    output logic             carry
);

    localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX / 10);
    localparam logic [BCD_W-1:0] MAX_U = BCD_W'(MAX % 10);

    logic at_max;

    assign at_max = (tens == MAX_T) && (units == MAX_U);
    assign carry  = inc && at_max;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens  <= '0;
            units <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens  <= '0;
                units <= '0;
            end else if (units == BCD_W'(9)) begin
                units <= '0;
                tens  <= tens + 1'b1;
            end else begin
                units <= units + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// 24-hour BCD clock with a two-field setting mode driven by mode/inc buttons
// and a blink phase for the field being edited.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int CLK_DIV   = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
    output logic [BCD_W-1:0] hour_t,
    output logic [BCD_W-1:0] hour_u,
    output logic [BCD_W-1:0] min_t,
    output logic [BCD_W-1:0] min_u,
    output logic [BCD_W-1:0] sec_t,
    output logic [BCD_W-1:0] sec_u,
    output logic [1:0]       mode,
    output logic             blank_hour,
    output logic             blank_min,
    output logic             sec_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    mode_t          st, st_nx;
    logic           mode_prev, inc_prev;
    logic           mode_press, inc_press, tick, run_tick;
    logic [PW-1:0]  presc;
    logic [BW-1:0]  blink, blink_nx;
    logic           phase, phase_nx;
    logic           sec_carry, min_carry, hour_carry_unused;
    logic           sec_clr, min_inc, hour_inc;

    // A coincident inc press is dropped in favour of the mode press.
    assign mode_press = btn_mode & ~mode_prev;
    assign inc_press  = btn_inc & ~inc_prev & ~mode_press;
    assign tick       = (presc == PW'(CLK_DIV - 1));
    assign run_tick   = (st == RUN) && tick && !mode_press;
    assign mode       = st;

    always_comb begin
        st_nx = st;
        if (mode_press) begin
            case (st)
                RUN:      st_nx = SET_HOUR;
                SET_HOUR: st_nx = SET_MIN;
                default:  st_nx = RUN;
            endcase
        end
    end

    always_comb begin
        blink_nx = blink + 1'b1;
        phase_nx = phase;
        if (mode_press) begin
            blink_nx = '0;
            phase_nx = 1'b0;
        end else if (blink == BW'(BLINK_DIV - 1)) begin
            blink_nx = '0;
            phase_nx = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= RUN;
            mode_prev  <= 1'b1;
            inc_prev   <= 1'b1;
            presc      <= '0;
            blink      <= '0;
            phase      <= 1'b0;
            sec_tick   <= 1'b0;
            blank_hour <= 1'b0;
            blank_min  <= 1'b0;
        end else begin
            st         <= st_nx;
            mode_prev  <= btn_mode;
            inc_prev   <= btn_inc;
            // Entering SET_HOUR or returning to RUN restarts the second.
            if (tick || (mode_press && st != SET_HOUR))
                presc <= '0;
            else
                presc <= presc + 1'b1;
            blink      <= blink_nx;
            phase      <= phase_nx;
            sec_tick   <= run_tick;
            blank_hour <= (st_nx == SET_HOUR) && phase_nx;
            blank_min  <= (st_nx == SET_MIN) && phase_nx;
        end
    end

    assign sec_clr  = mode_press && (st == RUN);
    assign min_inc  = (run_tick && sec_carry) || (inc_press && st == SET_MIN);
    assign hour_inc = (run_tick && min_carry) || (inc_press && st == SET_HOUR);

    bcd2_counter #(.MAX(MINSEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .clr(sec_clr), .inc(run_tick),
        .tens(sec_t), .units(sec_u), .carry(sec_carry)
    );

    bcd2_counter #(.MAX(MINSEC_MAX)) u_min (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(min_inc),
        .tens(min_t), .units(min_u), .carry(min_carry)
    );

    bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(hour_inc),
        .tens(hour_t), .units(hour_u), .carry(hour_carry_unused)
    );

endmodule
